// File: rtl/led_display_pkg.sv
// ---------------------------------------------------------------------------
// led_display_pkg
// Shared definitions for the multiplexed LED display scanner:
//   - scan_state_t      : scanner FSM state encoding
//   - BYTE_W / BIT_CNT_W: serializer byte width and bit-counter width
//   - LAST_BIT          : bit count value of the final (LSB) bit
//   - SHIFT_CLKS        : clocks per byte shift (2 clocks per bit)
//   - BRIGHT_LEVELS     : divisor of the brightness threshold
//   - digit_select_byte : one-hot digit-select byte for shifter A
// ---------------------------------------------------------------------------
package led_display_pkg;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_WAIT  = 2'd1,
        ST_LOAD  = 2'd2,
        ST_SHIFT = 2'd3
    } scan_state_t;

    localparam int BYTE_W        = 8;
    localparam int BIT_CNT_W     = 3;
    localparam logic [BIT_CNT_W-1:0] LAST_BIT = 3'd7;
    localparam int SHIFT_CLKS    = 2 * BYTE_W;
    localparam int BRIGHT_LEVELS = 16;

    // Digits occupy the top NUM_DIGITS bits of the select byte, so the
    // highest index drives bit 7 and index 0 drives bit (8 - num_digits).
    function automatic logic [BYTE_W-1:0] digit_select_byte(
        input int         num_digits,
        input logic [2:0] index
    );
        int amt;
        amt = BYTE_W - num_digits + int'(index);
        return BYTE_W'(1) << amt;
    endfunction

endpackage

// File: rtl/led_shift_serializer.sv
// ---------------------------------------------------------------------------
// led_shift_serializer
// Shifts one byte MSB first into an external 74HC164-style shift register.
// Each bit takes two clocks: cp low, then cp high; ds holds the bit for both
// clocks so it is stable across the cp rise. A full byte takes 16 clocks.
//
// Parameters:
//   INVERT_DS  - invert ds while shifting (idle/reset ds is always 0)
// Ports:
//   i_clk      - clock
//   i_reset_n  - asynchronous active-low reset, aborts any shift
//   i_load     - capture i_data and start shifting
//   i_data     - byte to shift
//   o_ds       - serial data
//   o_cp       - shift clock
//   o_busy     - high while a byte is being shifted
//   o_last     - high during the final clock of the byte
// ---------------------------------------------------------------------------
module led_shift_serializer
    import led_display_pkg::*;
#(
    parameter bit INVERT_DS = 1'b0
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_load,
    input  logic [BYTE_W-1:0] i_data,
    output logic              o_ds,
    output logic              o_cp,
    output logic              o_busy,
    output logic              o_last
);

    logic [BYTE_W-1:0]    r_shreg;
    logic [BIT_CNT_W-1:0] r_bit_cnt;
    logic                 r_phase;    // 0: cp low half, 1: cp high half
    logic                 r_busy;

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values; blocking here would create order races.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_shreg   <= '0;
            r_bit_cnt <= '0;
            r_phase   <= 1'b0;
            r_busy    <= 1'b0;
        end else if (i_load) begin
            r_shreg   <= i_data;
            r_bit_cnt <= '0;
            r_phase   <= 1'b0;
            r_busy    <= 1'b1;
        end else if (r_busy) begin
            if (!r_phase) begin
                r_phase <= 1'b1;
            end else begin
                r_phase <= 1'b0;
                if (r_bit_cnt == LAST_BIT) begin
                    r_busy <= 1'b0;
                end else begin
                    // Shift only after the cp-high half so ds never changes
                    // around the rising edge.
                    r_shreg   <= {r_shreg[BYTE_W-2:0], 1'b0};
                    r_bit_cnt <= r_bit_cnt + BIT_CNT_W'(1);
                end
            end
        end
    end

    assign o_cp   = r_busy & r_phase;
    assign o_ds   = r_busy & (r_shreg[BYTE_W-1] ^ INVERT_DS);
    assign o_busy = r_busy;
    assign o_last = r_busy & r_phase & (r_bit_cnt == LAST_BIT);

endmodule

// File: rtl/led_display_scanner.sv
// ---------------------------------------------------------------------------
// led_display_scanner
// Multiplexed 7-segment display scanner driving two serial shift registers:
// shifter A selects the digit (one-hot), shifter B carries the segments.
// Digits are written into a shadow buffer; the shadow is copied into the
// active buffer only at a frame boundary, so a frame never tears.
// Each digit period is exactly REFRESH_DIV clocks; the divider free-runs
// through LOAD and SHIFT.
//
// Optional feature: define LED_DISPLAY_BRIGHTNESS_EN to add i_brightness.
// Partway through each digit period a blank byte is shifted into B (A keeps
// the same digit), shortening on-time. Level 15 never blanks.
//
// Parameters:
//   NUM_DIGITS   - multiplexed digits (2..8)
//   REFRESH_DIV  - clocks per digit period (>= 64)
//   DIV_WIDTH    - divider width (2**DIV_WIDTH > REFRESH_DIV)
//   COMMON_ANODE - 1 inverts both ds outputs
// Ports:
//   i_clk, i_reset_n             - clock, asynchronous active-low reset
//   i_wr_stb/i_wr_digit/i_wr_data- shadow write port (a..g,DP, 1 = lit)
//   o_wr_ack                     - one-clock ack after each write strobe
//   i_blank                      - force all segments off
//   i_brightness                 - brightness level (feature build only)
//   o_frame_stb                  - one-clock pulse at each frame boundary
//   o_shifter_a_ds/cp/mr_n       - digit-select shift register
//   o_shifter_b_ds/cp/mr_n       - segment shift register
// ---------------------------------------------------------------------------
module led_display_scanner
    import led_display_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 62000,
    parameter int DIV_WIDTH    = 16,
    parameter bit COMMON_ANODE = 1'b1
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_wr_stb,
    input  logic [2:0] i_wr_digit,
    input  logic [7:0] i_wr_data,
    output logic       o_wr_ack,
    input  logic       i_blank,
`ifdef LED_DISPLAY_BRIGHTNESS_EN
    input  logic [3:0] i_brightness,
`endif
    output logic       o_frame_stb,
    output logic       o_shifter_a_ds,
    output logic       o_shifter_a_cp,
    output logic       o_shifter_a_mr_n,
    output logic       o_shifter_b_ds,
    output logic       o_shifter_b_cp,
    output logic       o_shifter_b_mr_n
);

    localparam int                   IDX_W    = 3;
    localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(NUM_DIGITS - 1);
    localparam logic [DIV_WIDTH-1:0] DIV_LAST = DIV_WIDTH'(REFRESH_DIV - 1);

    scan_state_t          r_state;
    scan_state_t          w_state_next;
    logic [DIV_WIDTH-1:0] r_div;
    logic                 w_div_tc;
    logic [IDX_W-1:0]     r_index;
    logic [BYTE_W-1:0]    r_shadow [NUM_DIGITS];
    logic [BYTE_W-1:0]    r_active [NUM_DIGITS];
    logic                 r_wr_ack;
    logic                 r_frame_stb;
    logic                 r_mr_n;

    logic [BYTE_W-1:0]    w_active_sel;
    logic [BYTE_W-1:0]    w_a_byte;
    logic [BYTE_W-1:0]    w_b_byte;
    logic                 w_load;
    logic                 w_blank_shift;
    logic                 w_serializers_idle;
    logic                 w_shift_done;
    logic                 w_a_busy;
    logic                 w_b_busy;
    logic                 w_a_last;
    logic                 w_b_last;

    // -----------------------------------------------------------------------
    // Digit-period divider: held at 0 in CLEAR, then free-running modulo
    // REFRESH_DIV regardless of FSM state.
    // -----------------------------------------------------------------------
    assign w_div_tc = (r_div == DIV_LAST);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_div <= '0;
        end else if (r_state == ST_CLEAR || w_div_tc) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + DIV_WIDTH'(1);
        end
    end

`ifdef LED_DISPLAY_BRIGHTNESS_EN
    // -----------------------------------------------------------------------
    // Brightness: a blank shift at count (level+1)*REFRESH_DIV/16. It is
    // only taken when it can finish before the next terminal count, so the
    // digit period is never stretched; level 15 lands on REFRESH_DIV itself
    // and therefore never blanks.
    // -----------------------------------------------------------------------
    localparam int TH_W = DIV_WIDTH + 5;

    logic [TH_W-1:0]   w_threshold;
    logic [TH_W-1:0]   w_div_next;
    logic              w_blank_fits;
    logic              w_blank_hit;
    logic              r_blank_done;
    logic              r_cur_blank;
    logic [BYTE_W-1:0] r_a_snap;

    assign w_threshold  = ((TH_W'(i_brightness) + TH_W'(1)) * TH_W'(REFRESH_DIV))
                          / TH_W'(BRIGHT_LEVELS);
    assign w_div_next   = TH_W'(r_div) + TH_W'(1);
    assign w_blank_fits = (w_threshold + TH_W'(SHIFT_CLKS + 1)) <= TH_W'(REFRESH_DIV - 1);
    assign w_blank_hit  = !r_blank_done && w_blank_fits && (w_div_next >= w_threshold);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_blank_done <= 1'b1;   // no blank before the first real digit
            r_cur_blank  <= 1'b0;
            r_a_snap     <= '0;
        end else begin
            if (r_state == ST_WAIT && w_state_next == ST_LOAD) begin
                r_cur_blank <= !w_div_tc;
            end
            if (w_load) begin
                if (r_cur_blank) begin
                    r_blank_done <= 1'b1;
                end else begin
                    r_blank_done <= 1'b0;
                    r_a_snap     <= w_a_byte;
                end
            end
        end
    end

    // The index has already advanced when the blank shift runs, so the
    // digit select comes from the snapshot taken at the real LOAD.
    assign w_blank_shift = r_cur_blank;
    assign w_a_byte      = r_cur_blank ? r_a_snap : digit_select_byte(NUM_DIGITS, r_index);
`else
    assign w_blank_shift = 1'b0;
    assign w_a_byte      = digit_select_byte(NUM_DIGITS, r_index);
`endif

    // -----------------------------------------------------------------------
    // Scanner FSM
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= ST_CLEAR;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: the next state gets a default before the case so every path
    // assigns it; a missing branch would otherwise infer a latch.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_CLEAR: w_state_next = ST_WAIT;
            ST_WAIT: begin
                if (w_div_tc) begin
                    w_state_next = ST_LOAD;
                end
`ifdef LED_DISPLAY_BRIGHTNESS_EN
                else if (w_blank_hit) begin
                    w_state_next = ST_LOAD;
                end
`endif
            end
            ST_LOAD: begin
                if (w_serializers_idle) begin
                    w_state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (w_shift_done) begin
                    w_state_next = ST_WAIT;
                end
            end
            default: w_state_next = ST_CLEAR;
        endcase
    end

    // mr_n is low during reset and for the single CLEAR clock after it.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_mr_n <= 1'b0;
        end else begin
            r_mr_n <= (w_state_next != ST_CLEAR);
        end
    end

    // -----------------------------------------------------------------------
    // Buffers, digit index, write ack and frame strobe
    // -----------------------------------------------------------------------
    always_comb begin
        w_active_sel = '0;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (r_index == IDX_W'(d)) begin
                w_active_sel = r_active[d];
            end
        end
    end

    // NOTE: the buffers are small register arrays rather than RAM, so they
    // can be cleared in the reset branch; a dark first frame relies on it.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_index     <= LAST_IDX;
            r_wr_ack    <= 1'b0;
            r_frame_stb <= 1'b0;
            for (int d = 0; d < NUM_DIGITS; d++) begin
                r_shadow[d] <= '0;
                r_active[d] <= '0;
            end
        end else begin
            r_wr_ack    <= i_wr_stb;
            r_frame_stb <= 1'b0;

            if (r_state == ST_CLEAR) begin
                r_index <= LAST_IDX;
            end else if (r_state == ST_SHIFT && w_shift_done && !w_blank_shift) begin
                if (r_index == '0) begin
                    r_index     <= LAST_IDX;
                    r_frame_stb <= 1'b1;
                    for (int d = 0; d < NUM_DIGITS; d++) begin
                        r_active[d] <= r_shadow[d];
                    end
                end else begin
                    r_index <= r_index - IDX_W'(1);
                end
            end

            // The copy above reads the pre-edge shadow, so a write on the
            // copy edge is held in shadow for the following frame.
            // Out-of-range digits match no entry and are dropped.
            for (int d = 0; d < NUM_DIGITS; d++) begin
                if (i_wr_stb && i_wr_digit == IDX_W'(d)) begin
                    r_shadow[d] <= i_wr_data;
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Serializers: both run in lockstep from the same load pulse.
    // -----------------------------------------------------------------------
    assign w_b_byte           = (w_blank_shift || i_blank) ? '0 : w_active_sel;
    assign w_serializers_idle = !(w_a_busy || w_b_busy);
    assign w_load             = (r_state == ST_LOAD) && w_serializers_idle;
    assign w_shift_done       = w_a_last && w_b_last;

    led_shift_serializer #(
        .INVERT_DS (COMMON_ANODE)
    ) u_ser_a (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_load    (w_load),
        .i_data    (w_a_byte),
        .o_ds      (o_shifter_a_ds),
        .o_cp      (o_shifter_a_cp),
        .o_busy    (w_a_busy),
        .o_last    (w_a_last)
    );

    led_shift_serializer #(
        .INVERT_DS (COMMON_ANODE)
    ) u_ser_b (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_load    (w_load),
        .i_data    (w_b_byte),
        .o_ds      (o_shifter_b_ds),
        .o_cp      (o_shifter_b_cp),
        .o_busy    (w_b_busy),
        .o_last    (w_b_last)
    );

    assign o_shifter_a_mr_n = r_mr_n;
    assign o_shifter_b_mr_n = r_mr_n;
    assign o_wr_ack         = r_wr_ack;
    assign o_frame_stb      = r_frame_stb;

endmodule

// File: doc/led_display_scanner.md
LED_DISPLAY_SCANNER -- requirements
Module: led_display_scanner

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, number of multiplexed digits (legal 2..8).
REQ-002 SHALL have parameter REFRESH_DIV, default 62000, clocks per digit period (legal >= 64).
REQ-003 SHALL have parameter DIV_WIDTH, default 16, divider counter width (2**DIV_WIDTH > REFRESH_DIV).
REQ-004 SHALL have parameter COMMON_ANODE, default 1, which inverts both ds outputs when 1.
REQ-005 SHALL have port i_clk, input, 1, the single clock.
REQ-006 SHALL have port i_reset_n, input, 1, reset; one clock; reset is asynchronous and active-low.
REQ-007 SHALL have ports i_wr_stb (1), i_wr_digit (3) and i_wr_data (8, a..g,DP, 1=lit), all inputs, forming the digit write port.
REQ-008 SHALL have port o_wr_ack, output, 1, write acknowledge.
REQ-009 SHALL have port i_blank, input, 1, which forces all segments off.
REQ-010 SHALL have port o_frame_stb, output, 1, frame-boundary pulse.
REQ-011 SHALL have ports o_shifter_a_ds/cp/mr_n (digit select) and o_shifter_b_ds/cp/mr_n (segments), all outputs, 1 bit each.

Function
REQ-012 SHALL hold a shadow buffer and an active buffer of NUM_DIGITS x 8 bits; writes go to shadow only.
REQ-013 o_wr_ack SHALL pulse one clock after each i_wr_stb; writes with i_wr_digit >= NUM_DIGITS SHALL be acked and discarded.
REQ-014 FSM states SHALL be CLEAR, WAIT, LOAD, SHIFT; reset enters CLEAR.
REQ-015 CLEAR SHALL drive both mr_n low for one clock, then go to WAIT with digit index = NUM_DIGITS-1.
REQ-016 WAIT SHALL count REFRESH_DIV clocks; on terminal count go to LOAD; the count SHALL continue through LOAD/SHIFT so the period is exactly REFRESH_DIV.
REQ-017 LOAD SHALL snapshot the shifter A byte (one-hot bit 7-index... bit (8-NUM_DIGITS+index), rest 0) and the shifter B byte (active[index], or 0 when i_blank); lasts 1 clock.
REQ-018 SHIFT SHALL emit 8 bits MSB first on both channels in lockstep, 2 clocks per bit (cp low then high, ds stable across the cp rise); 16 clocks total, then WAIT.
REQ-019 Index SHALL decrement after each SHIFT; on wrap from 0 to NUM_DIGITS-1, shadow SHALL be copied to active and o_frame_stb SHALL pulse for one clock in the same cycle.
REQ-020 A write coinciding with the copy SHALL land in shadow after the copy and be shown next frame.
REQ-021 ds SHALL be inverted when COMMON_ANODE=1; cp and mr_n are never inverted.
REQ-022 A frame SHALL be NUM_DIGITS*REFRESH_DIV clocks; no tearing within a frame.

Reset
REQ-023 Reset assertion SHALL immediately set ds=0, cp=0, mr_n=0, o_wr_ack=0, o_frame_stb=0, both buffers=0, divider=0, state CLEAR, aborting any shift.
REQ-024 First LOAD after release SHALL occur REFRESH_DIV+1 clocks after release.

Configuration
REQ-025 With LED_DISPLAY_BRIGHTNESS_EN defined, input i_brightness[3:0] SHALL exist; at divider count (i_brightness+1)*REFRESH_DIV/16 a second blank shift (B byte 0, A byte unchanged) SHALL occur; level 15 SHALL produce no blank shift.
REQ-026 Without LED_DISPLAY_BRIGHTNESS_EN, i_brightness SHALL be absent and digits shown for the full period.

Structure
REQ-027 State encodings and the byte/bit-count constants SHALL live in package led_display_pkg.
REQ-028 The 8-bit serializer (load, shift, cp generation, busy) SHALL be sub-module led_shift_serializer, instantiated twice.

Verification
REQ-029 NUM_DIGITS=4, REFRESH_DIV=64, COMMON_ANODE=0: write digit2=0xA5 -> after next frame boundary, the digit-2 shift emits A byte 0x40 and B byte 0xA5.
REQ-030 COMMON_ANODE=1, same write -> ds bit stream is 0xBF and 0x5A.
REQ-031 Write digit5 with NUM_DIGITS=4 -> o_wr_ack pulses, buffers unchanged.
REQ-032 i_blank=1 during LOAD -> B byte 0x00; A byte unaffected.
REQ-033 Reset asserted at bit 3 of SHIFT -> same-cycle mr_n=0, cp=0; CLEAR then first LOAD at REFRESH_DIV+1 clocks after release.
REQ-034 Brightness enabled, REFRESH_DIV=64, level 7 -> blank shift starts at count 32; level 15 -> no blank shift.
